// File: rtl/block_row_reader.sv
// Consumer end of the block-store line interface. Steps the rotating store with
// next_line, latches the row at the store output and answers per-column queries.
module block_row_reader #(
  parameter int unsigned NUM_ROWS = 16,
  parameter int unsigned NUM_COLS = 9,
  parameter int unsigned TAG_W    = 4
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic [NUM_COLS+TAG_W-1:0] line,
  output logic                      next_line,
  input  logic                      frame_start,
  input  logic                      row_advance,
  input  logic [3:0]                col_idx,
  output logic                      block_present,
  output logic [TAG_W-1:0]          row_index,
  output logic                      row_valid,
  output logic                      busy,
  output logic                      tag_err,
  output logic                      overrun
);

  typedef enum logic [1:0] {StIdle, StSync, StStep, StLatch} state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    ptr_q, ptr_after;
  logic                next_line_q, next_line_d;
  logic [NUM_COLS-1:0] row_buf_q, row_buf_d;
  logic [TAG_W-1:0]    row_index_q, row_index_d;
  logic                row_valid_q, row_valid_d;
  logic                pending_q, pending_d;
  logic                tag_err_q, tag_err_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         col_bits;

  // Pointer value once any pulse issued this cycle has rotated the store.
  always_comb begin
    ptr_after = ptr_q;
    if (next_line_q) begin
      ptr_after = (ptr_q == TAG_W'(NUM_ROWS - 1)) ? '0 : ptr_q + TAG_W'(1);
    end
  end

  // Next-state, pulse generation, latching and sticky error flags.
  always_comb begin
    state_d     = state_q;
    next_line_d = 1'b0;
    row_buf_d   = row_buf_q;
    row_index_d = row_index_q;
    row_valid_d = row_valid_q;
    pending_d   = pending_q;
    tag_err_d   = tag_err_q;
    overrun_d   = overrun_q;

    if (frame_start) begin
      // Realignment wins over everything; a coincident row_advance is dropped.
      pending_d = 1'b0;
      if (ptr_after == '0) begin
        state_d = StLatch;
      end else begin
        state_d     = StSync;
        next_line_d = 1'b1;
      end
    end else begin
      if (row_advance && (state_q != StIdle)) begin
        if (pending_q) overrun_d = 1'b1;
        else           pending_d = 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (row_advance || pending_q) begin
            state_d     = StStep;
            next_line_d = 1'b1;
            // A fresh request arriving while a pending one is served is kept.
            pending_d   = row_advance && pending_q;
          end
        end
        StSync: begin
          if (ptr_after == '0) state_d = StLatch;
          else                 next_line_d = 1'b1;
        end
        StStep: state_d = StLatch;
        StLatch: begin
          row_buf_d   = line[NUM_COLS+TAG_W-1:TAG_W];
          row_index_d = ptr_q;
          row_valid_d = 1'b1;
          if (line[TAG_W-1:0] != ptr_q) tag_err_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // The buffer no longer matches the store output once it starts rotating.
    if (next_line_d) row_valid_d = 1'b0;
  end

  // State and datapath registers, asynchronously reset with the store.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      next_line_q <= 1'b0;
      row_buf_q   <= '0;
      row_index_q <= '0;
      row_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      tag_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_after;
      next_line_q <= next_line_d;
      row_buf_q   <= row_buf_d;
      row_index_q <= row_index_d;
      row_valid_q <= row_valid_d;
      pending_q   <= pending_d;
      tag_err_q   <= tag_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Zero-extend so out-of-range column queries read as empty.
  assign col_bits      = 16'(row_buf_q);
  assign block_present = row_valid_q & col_bits[col_idx];

  assign next_line = next_line_q;
  assign row_index = row_index_q;
  assign row_valid = row_valid_q;
  assign busy      = (state_q != StIdle);
  assign tag_err   = tag_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_block_row_reader.sv
// Directed bench for block_row_reader with a behavioural rotating block store.
module tb_block_row_reader;

  logic        clk = 1'b0;
  logic        nRst;
  logic [12:0] line;
  logic        next_line;
  logic        frame_start;
  logic        row_advance;
  logic [3:0]  col_idx;
  logic        block_present;
  logic [3:0]  row_index;
  logic        row_valid;
  logic        busy;
  logic        tag_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  logic [3:0] store_ptr;
  logic       tag_force;

  block_row_reader dut (
    .clk           (clk),
    .nRst          (nRst),
    .line          (line),
    .next_line     (next_line),
    .frame_start   (frame_start),
    .row_advance   (row_advance),
    .col_idx       (col_idx),
    .block_present (block_present),
    .row_index     (row_index),
    .row_valid     (row_valid),
    .busy          (busy),
    .tag_err       (tag_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Store contents: row 0 = 101010101, row 1 = 010101010, higher rows perturbed.
  function automatic logic [8:0] blocks(input logic [3:0] r);
    return (r[0] ? 9'h0AA : 9'h155) ^ {r[3:1], 6'b0};
  endfunction

  // Rotating store model sharing the reset.
  always @(posedge clk or negedge nRst) begin
    if (!nRst)          store_ptr <= 4'd0;
    else if (next_line) store_ptr <= store_ptr + 4'd1;
  end

  assign line = {blocks(store_ptr), (tag_force ? 4'h5 : store_ptr)};

  always @(posedge clk) begin
    if (next_line) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sweep every column index, including the out-of-range ones.
  task automatic check_row(input logic [8:0] exp_bits);
    logic [15:0] ev;
    ev = {7'b0, exp_bits};
    for (int c = 0; c < 16; c++) begin
      col_idx = 4'(c);
      #1;
      check_eq($sformatf("block_present col %0d", c), block_present, ev[c]);
    end
    col_idx = 4'd0;
  endtask

  task automatic do_advance(input logic [3:0] exp_row);
    int base;
    base = pulse_cnt;
    row_advance = 1'b1;
    tick();
    row_advance = 1'b0;
    check_eq("adv next_line", next_line, 1'b1);
    check_eq("adv busy", busy, 1'b1);
    check_eq("adv row_valid low", row_valid, 1'b0);
    tick();
    tick();
    check_eq("adv row_valid", row_valid, 1'b1);
    check_eq("adv busy done", busy, 1'b0);
    check_eq("adv row_index", row_index, exp_row);
    check_eq("adv pulses", pulse_cnt - base, 1);
    check_row(blocks(exp_row));
  endtask

  task automatic do_frame(input int exp_pulses, input logic with_adv);
    int base;
    int cycles;
    base = pulse_cnt;
    frame_start = 1'b1;
    row_advance = with_adv;
    tick();
    frame_start = 1'b0;
    row_advance = 1'b0;
    cycles = 0;
    while (busy && cycles < 40) begin
      tick();
      cycles++;
    end
    check_eq("frame latency", cycles, exp_pulses + 1);
    check_eq("frame pulses", pulse_cnt - base, exp_pulses);
    check_eq("frame row_valid", row_valid, 1'b1);
    check_eq("frame row_index", row_index, 4'd0);
    check_eq("frame store ptr", store_ptr, 4'd0);
    check_row(blocks(4'd0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " next_line"}, next_line, 1'b0);
    check_eq({tag, " busy"}, busy, 1'b0);
    check_eq({tag, " row_valid"}, row_valid, 1'b0);
    check_eq({tag, " row_index"}, row_index, 4'd0);
    check_eq({tag, " tag_err"}, tag_err, 1'b0);
    check_eq({tag, " overrun"}, overrun, 1'b0);
    check_eq({tag, " block_present"}, block_present, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    nRst        = 1'b0;
    frame_start = 1'b0;
    row_advance = 1'b0;
    col_idx     = 4'd0;
    tag_force   = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    nRst = 1'b1;
    tick();
    tick();
    check_eq("idle after reset row_valid", row_valid, 1'b0);
    check_eq("idle after reset next_line", next_line, 1'b0);

    // Aligned store: frame_start latches directly.
    do_frame(0, 1'b0);
    check_eq("first frame tag_err", tag_err, 1'b0);

    do_advance(4'd1);

    // Coincident row_advance is dropped; ptr=1 gives the longest sync.
    do_frame(15, 1'b1);
    check_eq("coincident overrun", overrun, 1'b0);
    base = pulse_cnt;
    tick();
    tick();
    tick();
    check_eq("coincident dropped pulses", pulse_cnt - base, 0);
    check_eq("coincident dropped busy", busy, 1'b0);

    for (int i = 1; i <= 3; i++) do_advance(4'(i));
    do_frame(13, 1'b0);
    check_eq("sync tag_err", tag_err, 1'b0);

    // Full lap through the store, wrapping 15 -> 0.
    for (int i = 1; i <= 16; i++) do_advance(4'(i));
    check_eq("wrap line tag", line[3:0], 4'd0);
    check_eq("wrap tag_err", tag_err, 1'b0);

    // Three requests back to back: one served now, one pending, one lost.
    base = pulse_cnt;
    row_advance = 1'b1;
    tick();
    tick();
    check_eq("pending no overrun", overrun, 1'b0);
    tick();
    row_advance = 1'b0;
    tick();
    tick();
    tick();
    check_eq("overrun set", overrun, 1'b1);
    check_eq("pending row_index", row_index, 4'd2);
    check_eq("pending row_valid", row_valid, 1'b1);
    check_eq("pending pulses", pulse_cnt - base, 2);
    tick();
    tick();
    check_eq("no third pulse", pulse_cnt - base, 2);
    check_eq("overrun sticky", overrun, 1'b1);

    // Faulty tag at row 0.
    tag_force = 1'b1;
    do_frame(14, 1'b0);
    check_eq("tag_err set", tag_err, 1'b1);
    tag_force = 1'b0;
    do_advance(4'd1);
    check_eq("tag_err sticky", tag_err, 1'b1);

    // Reset in the middle of a sync sequence.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    check_eq("mid sync busy", busy, 1'b1);
    check_eq("mid sync next_line", next_line, 1'b1);
    nRst = 1'b0;
    #1;
    check_reset_outputs("mid sync reset");
    check_eq("mid sync store ptr", store_ptr, 4'd0);
    tick();
    nRst = 1'b1;
    tick();
    tick();
    check_eq("post reset row_valid", row_valid, 1'b0);
    do_frame(0, 1'b0);
    check_eq("post reset tag_err", tag_err, 1'b0);
    check_eq("post reset overrun", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
